// File: rtl/sr_ff_monitor.sv
// Reference-model monitor for an SR flip-flop with clear/preset: tracks the expected
// output, compares the observed Q/P one cycle after each input sample, and counts checks and errors.
module sr_ff_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             S,
    input  logic             R,
    input  logic             CLR,
    input  logic             PR,
    input  logic             Q,
    input  logic             P,
    output logic             TRACKING,
    output logic             ERR,
    output logic             ERR_STICKY,
    output logic [CNT_W-1:0] CHK_CNT,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        TRACK   = 2'd1,
        INVALID = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_nx;
    logic   exp_q;
    logic   exp_nx;
    logic   armed;
    logic   defined_load;
    logic   invalid_cmd;
    logic   mismatch;

    // A defined load fixes the reference value regardless of its previous content.
    assign defined_load = !CLR || PR || (S ^ R);
    assign invalid_cmd  = CLR && !PR && S && R;
    assign mismatch     = (Q != exp_q) || (P == Q);
    assign state_dbg    = state;

    always_comb begin
        exp_nx = exp_q;
        if (!CLR) begin
            exp_nx = 1'b0;
        end else if (PR) begin
            exp_nx = 1'b1;
        end else begin
            case ({S, R})
                2'b01:   exp_nx = 1'b0;
                2'b10:   exp_nx = 1'b1;
                default: exp_nx = exp_q;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            UNKNOWN: if (defined_load) state_nx = TRACK;
            TRACK:   if (invalid_cmd)  state_nx = INVALID;
            INVALID: if (defined_load) state_nx = TRACK;
            default: state_nx = UNKNOWN;
        endcase
    end

    // The compare armed at edge k checks the Q/P seen at edge k+1 against exp_q from edge k.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= UNKNOWN;
            exp_q      <= 1'b0;
            armed      <= 1'b0;
            TRACKING   <= 1'b0;
            ERR        <= 1'b0;
            ERR_STICKY <= 1'b0;
            CHK_CNT    <= '0;
            ERR_CNT    <= '0;
        end else begin
            state    <= state_nx;
            exp_q    <= exp_nx;
            armed    <= (state_nx == TRACK);
            TRACKING <= (state_nx == TRACK);
            ERR      <= armed && mismatch;
            if (armed && (CHK_CNT != CNT_MAX)) begin
                CHK_CNT <= CHK_CNT + CNT_ONE;
            end
            if (armed && mismatch) begin
                ERR_STICKY <= 1'b1;
                if (ERR_CNT != CNT_MAX) begin
                    ERR_CNT <= ERR_CNT + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Directed bench for sr_ff_monitor: a driver pushes predicted outputs per edge, a monitor
// pops and compares; an 8-bit and a 2-bit counter instance share the same stimulus.
module tb_sr_ff_monitor;

    logic clk = 1'b0;
    logic rst, s, r, clr, pr, q, p;
    logic       trk8, err8, stk8, trk2, err2, stk2;
    logic [7:0] chk8, errc8;
    logic [1:0] chk2, errc2;
    logic [1:0] st8, st2;

    logic [24:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    // model state
    logic [1:0] m_state;
    logic       m_exp, m_armed, m_trk, m_err, m_stk;
    logic [7:0] m_chk8, m_errc8;
    logic [1:0] m_chk2, m_errc2;

    always #5 clk = ~clk;

    sr_ff_monitor #(.CNT_W(8)) u8 (
        .CLK(clk), .RST(rst), .S(s), .R(r), .CLR(clr), .PR(pr), .Q(q), .P(p),
        .TRACKING(trk8), .ERR(err8), .ERR_STICKY(stk8),
        .CHK_CNT(chk8), .ERR_CNT(errc8), .state_dbg(st8)
    );

    sr_ff_monitor #(.CNT_W(2)) u2 (
        .CLK(clk), .RST(rst), .S(s), .R(r), .CLR(clr), .PR(pr), .Q(q), .P(p),
        .TRACKING(trk2), .ERR(err2), .ERR_STICKY(stk2),
        .CHK_CNT(chk2), .ERR_CNT(errc2), .state_dbg(st2)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle and predict the outputs that follow the coming rising edge.
    task automatic step(input logic i_rst, input logic i_s, input logic i_r,
                        input logic i_clr, input logic i_pr, input logic i_q, input logic i_p);
        logic defined, e;
        @(negedge clk);
        rst = i_rst; s = i_s; r = i_r; clr = i_clr; pr = i_pr; q = i_q; p = i_p;
        if (i_rst) begin
            m_state = 2'd0; m_exp = 1'b0; m_armed = 1'b0; m_trk = 1'b0;
            m_err = 1'b0; m_stk = 1'b0; m_chk8 = 0; m_errc8 = 0; m_chk2 = 0; m_errc2 = 0;
        end else begin
            e = m_armed && ((i_q != m_exp) || (i_p != !i_q));
            m_err = e;
            if (m_armed) begin
                if (m_chk8 != 8'hff) m_chk8++;
                if (m_chk2 != 2'd3)  m_chk2++;
            end
            if (e) begin
                m_stk = 1'b1;
                if (m_errc8 != 8'hff) m_errc8++;
                if (m_errc2 != 2'd3)  m_errc2++;
            end
            defined = 1'b1;
            if (!i_clr)                m_exp = 1'b0;
            else if (i_pr)             m_exp = 1'b1;
            else if (!i_s && i_r)      m_exp = 1'b0;
            else if (i_s && !i_r)      m_exp = 1'b1;
            else                       defined = 1'b0;
            if (defined)
                m_state = 2'd1;
            else if (m_state == 2'd1 && i_s && i_r)
                m_state = 2'd2;
            m_armed = (m_state == 2'd1);
            m_trk   = m_armed;
        end
        exp_q.push_back({m_trk, m_err, m_stk, m_chk8, m_errc8, m_chk2, m_errc2, m_state});
    endtask

    // Well-behaved flip-flop: Q follows the current reference, P is its complement.
    task automatic ok(input logic i_s, input logic i_r, input logic i_clr, input logic i_pr);
        step(1'b0, i_s, i_r, i_clr, i_pr, m_exp, !m_exp);
    endtask

    task automatic do_reset();
        step(1'b1, 0, 0, 1, 0, 0, 1);
        step(1'b1, 0, 0, 1, 0, 0, 1);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one predicted record per driven edge.
    always @(posedge clk) begin
        logic [24:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("flags8", {5'd0, trk8, err8, stk8}, {5'd0, e[24:22]});
            check("flags2", {5'd0, trk2, err2, stk2}, {5'd0, e[24:22]});
            check("chk_cnt8", chk8, e[21:14]);
            check("err_cnt8", errc8, e[13:6]);
            check("cnts2", {4'd0, chk2, errc2}, {4'd0, e[5:2]});
            check("state", {4'd0, st8, st2}, {4'd0, e[1:0], e[1:0]});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; s = 0; r = 0; clr = 1; pr = 0; q = 0; p = 1;
        m_exp = 0; m_armed = 0; m_state = 0;

        // holds after reset stay UNKNOWN
        do_reset();
        for (int i = 0; i < 5; i++) ok(0, 0, 1, 0);
        settle();
        check("unk_trk", {7'd0, trk8}, 8'd0);
        check("unk_chk", chk8, 8'd0);
        check("unk_state", {6'd0, st8}, 8'd0);

        // correct set/hold/reset/hold sequence
        ok(1, 0, 1, 0);
        settle();
        check("load_trk", {7'd0, trk8}, 8'd1);
        ok(0, 0, 1, 0);
        ok(0, 1, 1, 0);
        ok(0, 0, 1, 0);
        ok(0, 0, 1, 0);
        settle();
        check("seq_chk", chk8, 8'd4);
        check("seq_err", {6'd0, errc8[0], stk8}, 8'd0);

        // S=R=1 suspends comparison until the next defined load
        do_reset();
        ok(1, 0, 1, 0);
        ok(1, 1, 1, 0);
        ok(1, 1, 1, 0);
        settle();
        check("inv_state", {6'd0, st8}, 8'd2);
        check("inv_chk", chk8, 8'd1);
        ok(0, 1, 1, 0);
        ok(0, 0, 1, 0);
        settle();
        check("inv_resume_chk", chk8, 8'd2);
        check("inv_sticky", {7'd0, stk8}, 8'd0);

        // clear beats preset; Q stuck high is caught
        do_reset();
        ok(0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1, 0);
        settle();
        check("clr_err", {6'd0, err8, stk8}, 8'd3);
        check("clr_errcnt", errc8, 8'd1);
        ok(0, 0, 1, 0);
        settle();
        check("err_pulse_end", {7'd0, err8}, 8'd0);

        // complement error with expected 1
        ok(0, 0, 1, 1);
        step(0, 0, 0, 1, 0, 1, 1);
        settle();
        check("comp_errcnt", errc8, 8'd2);

        // saturation of the 2-bit counters, then reset mid-stream
        do_reset();
        ok(1, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 1);
        settle();
        check("sat_errcnt8", errc8, 8'd5);
        check("sat_errcnt2", {6'd0, errc2}, 8'd3);
        check("sat_chkcnt2", {6'd0, chk2}, 8'd3);
        step(1, 0, 0, 1, 0, 0, 1);
        settle();
        check("rst_cnts", {errc8[3:0], chk2, errc2}, 8'd0);
        step(0, 0, 0, 1, 0, 0, 1);
        settle();
        check("post_rst_err", {6'd0, err8, err2}, 8'd0);
        check("post_rst_chk", chk8, 8'd0);

        repeat (2) @(posedge clk);
        #3;
        check("queue_empty", exp_q.size() == 0 ? 8'd1 : 8'd0, 8'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sr_ff_monitor.md
SR_FF_MONITOR -- requirements
Module: sr_ff_monitor

Interface
REQ-001 Parameter: CNT_W, default 8, width of the saturating counters CHK_CNT and ERR_CNT.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 S  input  1  set request driven to the observed SR flip-flop.
REQ-005 R  input  1  reset request driven to the observed SR flip-flop.
REQ-006 CLR  input  1  flip-flop clear, active-low, highest priority.
REQ-007 PR  input  1  flip-flop preset, active-high, below CLR.
REQ-008 Q  input  1  observed flip-flop true output.
REQ-009 P  input  1  observed flip-flop complement output.
REQ-010 TRACKING  output  1  high when the monitor's reference state is known.
REQ-011 ERR  output  1  one-cycle pulse on a detected mismatch.
REQ-012 ERR_STICKY  output  1  set on the first error; held until RST.
REQ-013 CHK_CNT  output  CNT_W  saturating count of comparisons performed.
REQ-014 ERR_CNT  output  CNT_W  saturating count of errors detected.

Function
REQ-015 The reference model SHALL compute exp_q at every rising edge with RST low, using this priority order:
- CLR=0 -> 0
- else PR=1 -> 1
- else S,R = 00 -> hold exp_q; 01 -> 0; 10 -> 1; 11 -> invalid.
REQ-016 The FSM SHALL have three states: UNKNOWN, TRACK and INVALID.
REQ-017 UNKNOWN (after reset) SHALL move to TRACK on a defined load: CLR=0, or PR=1, or S/R=01 or 10. S/R=00 SHALL stay in UNKNOWN.
REQ-018 TRACK SHALL stay in TRACK on any defined load or hold.
REQ-019 TRACK SHALL move to INVALID on S=R=1 with CLR=1 and PR=0.
REQ-020 INVALID SHALL move to TRACK on a defined load. Hold and S=R=1 SHALL stay in INVALID.
REQ-021 The monitor SHALL register inputs at edge k and compare Q/P at edge k+1 (one-cycle compare latency). The compare SHALL be armed only if the state resulting from edge k is TRACK.
REQ-022 An armed compare SHALL flag an error if Q != exp_q or P != ~Q. Either condition or both counts as one error per cycle.
REQ-023 An armed compare SHALL increment CHK_CNT by 1. Each error SHALL assert ERR for exactly that cycle, increment ERR_CNT and set ERR_STICKY.
REQ-024 No compare, and no counter change, SHALL occur in UNKNOWN or INVALID, nor in the first cycle after RST.
REQ-025 CHK_CNT and ERR_CNT SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-026 Simultaneous CLR=0 and PR=1 SHALL resolve to exp_q=0 (clear wins).
REQ-027 TRACKING SHALL equal (state==TRACK) as a registered output.

Reset
REQ-028 RST high at a rising edge SHALL force:
- state=UNKNOWN
- TRACKING=0
- ERR=0
- ERR_STICKY=0
- CHK_CNT=0
- ERR_CNT=0
- the compare pipeline disarmed.
REQ-029 Reset asserted mid-operation SHALL discard any pending compare; the next comparison requires a new defined load after RST falls.
REQ-030 No output SHALL change between edges.

Verification
REQ-031 Bench scenarios:
- RST 2 cycles, then S/R=00, CLR=1, PR=0 for 5 cycles -> state stays UNKNOWN, TRACKING=0, CHK_CNT=0.
- Correct DUT, sequence S/R=10, 00, 01, 00 (CLR=1, PR=0) -> TRACKING=1 from the cycle after the first load, CHK_CNT=4 after the last compare, ERR_CNT=0, ERR_STICKY=0.
- S/R=10, then S/R=11 for 2 cycles, then 01 -> no compare during INVALID, resumes after 01, ERR never asserted.
- CLR=0 with PR=1 while the DUT drives Q=1 -> ERR pulses 1 cycle, ERR_CNT=1, ERR_STICKY=1.
- Q=1, P=1 while exp_q=1 -> complement error, ERR_CNT increments by 1.
- CNT_W=2, force 5 errors -> ERR_CNT=3 (saturated); RST mid-sequence -> all counters 0 on the next cycle, no ERR in the cycle after RST.
